data_io_wide: RTL and testbench

Parametrised successor of the ARM-to-FPGA download channel. Receives the io-controller SPI stream (SS2 select), decodes commands, and packs downloaded bytes into DW-bit words. Words are buffered in a small FIFO and written to the core over an `ioctl_*` bus with `ioctl_wait` backpressure. All logic runs on `clk_sys`; the SPI pins are oversampled, with no second clock domain.

---
 rtl/data_io_pkg.sv | 12 +
 rtl/data_io_fifo.sv | 38 +++
 rtl/data_io_wide.sv | 173 +++++++++++++++++
 tb/tb_data_io_wide.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/data_io_pkg.sv
// data_io_pkg: command codes, ACK byte and address type for the data_io_wide download channel.
package data_io_pkg;
    localparam logic [7:0] CMD_ACK    = 8'h00;
    localparam logic [7:0] CMD_UPLOAD = 8'h10;
    localparam logic [7:0] CMD_STATUS = 8'h15;
    localparam logic [7:0] CMD_INDEX  = 8'h55;
    localparam logic [7:0] CMD_START  = 8'h61;
    localparam logic [7:0] CMD_END    = 8'h62;
    localparam logic [7:0] ACK_BYTE   = 8'h4B;
    localparam int ADDR_W = 25;
    typedef logic [ADDR_W-1:0] addr_t;
endpackage

// File: rtl/data_io_fifo.sv
// data_io_fifo: synchronous word/address FIFO; a push while full is accepted only alongside a pop.
module data_io_fifo #(
    parameter int W     = 33,
    parameter int DEPTH = 4
) (
    input  logic                   clk_sys,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic [W-1:0]           din,
    output logic [W-1:0]           dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic          do_push, do_pop;
    assign full    = count == (AW+1)'(DEPTH);
    assign empty   = count == '0;
    assign do_push = push & (~full | pop);
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rp];
    always_ff @(posedge clk_sys)
        if (do_push) mem[wp] <= din;
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (do_push) wp <= wp + 1'b1;
            if (do_pop) rp <= rp + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/data_io_wide.sv
// data_io_wide: oversampled SPI download channel packing bytes into DW-bit words behind a FIFO.
// Define DATA_IO_UPLOAD_EN to make command 0x10 return ioctl_din on SPI_DO.
module data_io_wide
    import data_io_pkg::*;
#(
    parameter int          DW         = 8,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [24:0] START_ADDR = 25'd0,
    parameter bit          BIG_ENDIAN = 1'b0
) (
    input  logic          clk_sys,
    input  logic          reset,
    input  logic          SPI_SCK,
    input  logic          SPI_SS2,
    input  logic          SPI_DI,
    output logic          SPI_DO,
    input  logic [7:0]    ioctl_din,
    input  logic          ioctl_wait,
    output logic [31:0]   status,
    output logic          ioctl_download,
    output logic [7:0]    ioctl_index,
    output logic          ioctl_wr,
    output logic [24:0]   ioctl_addr,
    output logic [DW-1:0] ioctl_dout,
    output logic          ioctl_overflow
);
    localparam int LANES = DW / 8;
    localparam int CW    = $clog2(FIFO_DEPTH) + 1;
    localparam logic [1:0] LAST = 2'(LANES - 1);
    typedef struct packed {
        addr_t         addr;
        logic [DW-1:0] data;
    } entry_t;

    logic [2:0]    sck_q;
    logic [1:0]    ss_q, di_q;
    logic [2:0]    bit_cnt, byte_cnt;
    logic [6:0]    sr;
    logic [7:0]    cmd, index_reg, do_sr, rx_byte, eff_cmd, resp;
    logic          do_out, end_pend, rise, fall, active, byte_done, data_byte, pop;
    logic [1:0]    pk_cnt, st_lane;
    logic [DW-1:0] pk_word, word_next;
    addr_t         addr;
    logic          push, full, empty;
    entry_t        push_entry, head, last;
    logic [CW-1:0] count;

    assign rise      = sck_q[1] & ~sck_q[2];
    assign fall      = ~sck_q[1] & sck_q[2];
    assign active    = ~ss_q[1];
    assign rx_byte   = {sr, di_q[1]};
    assign byte_done = rise & active & (bit_cnt == 3'd7);
    assign eff_cmd   = byte_cnt == '0 ? rx_byte : cmd;
    assign data_byte = byte_done & (byte_cnt != '0) & (cmd == CMD_START);
    assign st_lane   = 2'(3'd4 - byte_cnt);
    assign word_next = pk_word | (DW'(rx_byte) << (BIG_ENDIAN ? DW - 8 - 8 * int'(pk_cnt) : 8 * int'(pk_cnt)));
    assign pop        = ~empty & ~ioctl_wait;
    assign ioctl_wr   = pop;
    assign ioctl_addr = pop ? head.addr : last.addr;
    assign ioctl_dout = pop ? head.data : last.data;
    assign SPI_DO     = SPI_SS2 ? 1'bz : do_out;

    always_comb begin
        resp = 8'h00;
        if (eff_cmd == CMD_ACK) resp = ACK_BYTE;
`ifdef DATA_IO_UPLOAD_EN
        if (eff_cmd == CMD_UPLOAD) resp = ioctl_din;
`endif
    end
`ifndef DATA_IO_UPLOAD_EN
    logic unused_din;
    assign unused_din = ^{ioctl_din, CMD_UPLOAD};
`endif

    data_io_fifo #(.W(DW + ADDR_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_sys(clk_sys),
        .reset  (reset),
        .push   (push),
        .pop    (pop),
        .din    (push_entry),
        .dout   (head),
        .full   (full),
        .empty  (empty),
        .count  (count)
    );

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            sck_q          <= '0;
            ss_q           <= '1;
            di_q           <= '0;
            bit_cnt        <= '0;
            byte_cnt       <= '0;
            sr             <= '0;
            cmd            <= '0;
            index_reg      <= '0;
            do_sr          <= '0;
            do_out         <= 1'b0;
            end_pend       <= 1'b0;
            pk_cnt         <= '0;
            pk_word        <= '0;
            addr           <= START_ADDR;
            push           <= 1'b0;
            push_entry     <= '0;
            last           <= '0;
            status         <= '0;
            ioctl_download <= 1'b0;
            ioctl_index    <= '0;
            ioctl_overflow <= 1'b0;
        end else begin
            sck_q <= {sck_q[1:0], SPI_SCK};
            ss_q  <= {ss_q[0], SPI_SS2};
            di_q  <= {di_q[0], SPI_DI};
            push  <= 1'b0;
            if (pop) last <= head;
            if (push & full & ~pop) ioctl_overflow <= 1'b1;
            // The last write of an ended download drops the flag in the following cycle.
            if (end_pend & ~push & (empty | (count == CW'(1) & pop))) begin
                ioctl_download <= 1'b0;
                end_pend       <= 1'b0;
            end
            if (!active) begin
                bit_cnt  <= '0;
                byte_cnt <= '0;
            end else if (rise) begin
                sr      <= rx_byte[6:0];
                bit_cnt <= bit_cnt + 1'b1;
            end
            if (fall) begin
                do_out <= do_sr[7];
                do_sr  <= {do_sr[6:0], 1'b0};
            end
            if (byte_done) begin
                byte_cnt <= byte_cnt + {2'b0, byte_cnt != 3'd7};
                do_sr    <= resp;
                if (byte_cnt == '0) cmd <= rx_byte;
                if (byte_cnt != '0 && cmd == CMD_INDEX) index_reg <= rx_byte;
                if (byte_cnt != '0 && byte_cnt <= 3'd4 && cmd == CMD_STATUS) status[{st_lane, 3'b000} +: 8] <= rx_byte;
            end
            if (byte_done && byte_cnt == '0 && rx_byte == CMD_START) begin
                ioctl_download <= 1'b1;
                ioctl_index    <= index_reg;
                ioctl_overflow <= 1'b0;
                addr           <= START_ADDR;
                pk_cnt         <= '0;
                pk_word        <= '0;
                end_pend       <= 1'b0;
            end
            if (byte_done && byte_cnt == '0 && rx_byte == CMD_END) begin
                end_pend <= 1'b1;
                if (pk_cnt != '0) begin
                    push       <= 1'b1;
                    push_entry <= {addr, pk_word};
                    addr       <= addr + addr_t'(LANES);
                    pk_cnt     <= '0;
                    pk_word    <= '0;
                end
            end
            if (data_byte) begin
                if (pk_cnt == LAST) begin
                    push       <= 1'b1;
                    push_entry <= {addr, word_next};
                    addr       <= addr + addr_t'(LANES);
                    pk_cnt     <= '0;
                    pk_word    <= '0;
                end else begin
                    pk_cnt  <= pk_cnt + 1'b1;
                    pk_word <= word_next;
                end
            end
        end
    end
endmodule

// File: tb/tb_data_io_wide.sv
// tb_data_io_wide: scoreboard bench driving three data_io_wide builds (16-bit LE, 32-bit BE, 8-bit) over SPI.
module tb_data_io_wide;
    logic        clk = 1'b0, reset = 1'b1, sck = 1'b0, di = 1'b0;
    logic [2:0]  ss = 3'b111, wt = 3'b000;
    logic [7:0]  din = 8'hA5;
    logic [7:0]  tx[$];
    logic [7:0]  rx_last;
    wire  [2:0]  spi_do, dl, wr, ov;
    wire  [31:0] status [3];
    wire  [7:0]  idx [3];
    wire  [24:0] addr [3];
    wire  [15:0] dout16;
    wire  [31:0] dout32;
    wire  [7:0]  dout8;
    logic [40:0] q16[$];
    logic [56:0] q32[$];
    logic [32:0] q8[$];
    logic [40:0] e16;
    logic [56:0] e32;
    logic [32:0] e8;
    int n_pass = 0, n_total = 0;

    always #5 clk = ~clk;

    data_io_wide #(.DW(16)) u16 (
        .clk_sys(clk), .reset(reset), .SPI_SCK(sck), .SPI_SS2(ss[0]), .SPI_DI(di), .SPI_DO(spi_do[0]),
        .ioctl_din(din), .ioctl_wait(wt[0]), .status(status[0]), .ioctl_download(dl[0]),
        .ioctl_index(idx[0]), .ioctl_wr(wr[0]), .ioctl_addr(addr[0]), .ioctl_dout(dout16), .ioctl_overflow(ov[0]));
    data_io_wide #(.DW(32), .BIG_ENDIAN(1'b1)) u32 (
        .clk_sys(clk), .reset(reset), .SPI_SCK(sck), .SPI_SS2(ss[1]), .SPI_DI(di), .SPI_DO(spi_do[1]),
        .ioctl_din(din), .ioctl_wait(wt[1]), .status(status[1]), .ioctl_download(dl[1]),
        .ioctl_index(idx[1]), .ioctl_wr(wr[1]), .ioctl_addr(addr[1]), .ioctl_dout(dout32), .ioctl_overflow(ov[1]));
    data_io_wide #(.DW(8), .FIFO_DEPTH(4)) u8 (
        .clk_sys(clk), .reset(reset), .SPI_SCK(sck), .SPI_SS2(ss[2]), .SPI_DI(di), .SPI_DO(spi_do[2]),
        .ioctl_din(din), .ioctl_wait(wt[2]), .status(status[2]), .ioctl_download(dl[2]),
        .ioctl_index(idx[2]), .ioctl_wr(wr[2]), .ioctl_addr(addr[2]), .ioctl_dout(dout8), .ioctl_overflow(ov[2]));

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Sends tx as one SS2-framed transaction; rx_last keeps the DO bits of the final byte.
    task automatic spi_xfer(input int d);
        ss[d] = 1'b0;
        repeat (6) @(negedge clk);
        foreach (tx[k]) begin
            for (int i = 7; i >= 0; i--) begin
                di = tx[k][i];
                repeat (6) @(negedge clk);
                rx_last[i] = spi_do[d];
                sck = 1'b1;
                repeat (6) @(negedge clk);
                sck = 1'b0;
            end
        end
        repeat (6) @(negedge clk);
        ss[d] = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (!reset && wr[0]) begin
            if (q16.size() == 0) begin
                n_total++;
                $display("FAIL wr16 unexpected: got %0h@%0h expected none", dout16, addr[0]);
            end else begin
                e16 = q16.pop_front();
                check("wr16", {23'b0, addr[0], dout16}, {23'b0, e16});
            end
        end
        if (!reset && wr[1]) begin
            if (q32.size() == 0) begin
                n_total++;
                $display("FAIL wr32 unexpected: got %0h@%0h expected none", dout32, addr[1]);
            end else begin
                e32 = q32.pop_front();
                check("wr32", {7'b0, addr[1], dout32}, {7'b0, e32});
            end
        end
        if (!reset && wr[2]) begin
            if (q8.size() == 0) begin
                n_total++;
                $display("FAIL wr8 unexpected: got %0h@%0h expected none", dout8, addr[2]);
            end else begin
                e8 = q8.pop_front();
                check("wr8", {31'b0, addr[2], dout8}, {31'b0, e8});
            end
        end
    end

    initial begin
        repeat (4) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_status", status[0], 0);
        check("rst_index", idx[0], 0);
        check("rst_download", dl[0], 0);
        check("rst_wr", wr, 0);
        check("rst_addr", addr[0], 0);
        check("rst_dout", dout16, 0);
        check("rst_overflow", ov, 0);

        // DW=16 little-endian download
        q16.push_back({25'd0, 16'hBBAA});
        q16.push_back({25'd2, 16'hDDCC});
        tx = {8'h55, 8'h03};
        spi_xfer(0);
        tx = {8'h61, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
        spi_xfer(0);
        check("t1_index", idx[0], 8'h03);
        check("t1_download_active", dl[0], 1);
        tx = {8'h62};
        spi_xfer(0);
        repeat (20) @(negedge clk);
        check("t1_download_done", dl[0], 0);
        check("t1_dout_hold", dout16, 16'hDDCC);
        check("t1_addr_hold", addr[0], 2);

        // DW=32 big-endian with a zero-padded flush
        q32.push_back({25'd0, 32'h01020304});
        q32.push_back({25'd4, 32'h05000000});
        tx = {8'h61, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        spi_xfer(1);
        tx = {8'h62};
        spi_xfer(1);
        repeat (20) @(negedge clk);
        check("t2_download_done", dl[1], 0);

        // DW=8 overflow while the core stalls
        wt[2] = 1'b1;
        for (int i = 0; i < 4; i++) q8.push_back({25'(i), 8'(8'h10 + i)});
        tx = {8'h61, 8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15};
        spi_xfer(2);
        check("t3_overflow", ov[2], 1);
        check("t3_no_write", wr[2], 0);
        tx = {8'h62};
        spi_xfer(2);
        check("t3_download_held", dl[2], 1);
        wt[2] = 1'b0;
        repeat (20) @(negedge clk);
        check("t3_download_done", dl[2], 0);
        check("t3_overflow_sticky", ov[2], 1);

        // status load and DO responses
        tx = {8'h15, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A};
        spi_xfer(0);
        check("t4_status", status[0], 32'h12345678);
        tx = {8'h00, 8'h00};
        spi_xfer(0);
        check("t4_ack", rx_last, 8'h4B);
        tx = {8'h33, 8'h00};
        spi_xfer(0);
        check("t4_unknown", rx_last, 8'h00);

        // reset mid-download discards the buffered word
        wt[0] = 1'b1;
        tx = {8'h61, 8'h11, 8'h22};
        spi_xfer(0);
        check("t5_download_active", dl[0], 1);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        wt[0] = 1'b0;
        repeat (4) @(negedge clk);
        check("t5_status", status[0], 0);
        check("t5_index", idx[0], 0);
        check("t5_download", dl[0], 0);
        check("t5_wr", wr[0], 0);
        check("t5_addr", addr[0], 0);
        check("t5_dout", dout16, 0);
        q16.push_back({25'd0, 16'hFFEE});
        tx = {8'h61, 8'hEE, 8'hFF};
        spi_xfer(0);
        check("t5_overflow_clear", ov[0], 0);
        tx = {8'h62};
        spi_xfer(0);

        // upload command
        tx = {8'h10, 8'h00};
        spi_xfer(0);
`ifdef DATA_IO_UPLOAD_EN
        check("t6_upload", rx_last, 8'hA5);
`else
        check("t6_upload", rx_last, 8'h00);
`endif

        for (int i = 0; i < 200 && (q16.size() + q32.size() + q8.size()) != 0; i++) @(negedge clk);
        check("drain_queues", 64'(q16.size() + q32.size() + q8.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
